// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and type definitions shared by the 16-bit pipelined CPU.
//   CPU_DATA_W  - datapath / address width
//   CPU_REG_W   - register index width
//   CPU_TIMEOUT - default cycle budget for a data memory access (used when
//                 mem_stage is built with MEM_TIMEOUT_EN)
//   mem_state_e - mem_stage FSM encoding (IDLE=0, ACCESS=1)
package cpu_pkg;

  localparam int CPU_DATA_W  = 16;
  localparam int CPU_REG_W   = 3;
  localparam int CPU_TIMEOUT = 15;

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: counts waiting cycles of an outstanding data memory access.
// Ports:
//   Clk, Reset_n - clock, asynchronous active-low reset
//   clear_i      - restart the count (held while the access FSM is idle)
//   enable_i     - one more cycle spent waiting for the acknowledge
//   expired_o    - current cycle is the TIMEOUT-th waiting cycle
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 15,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Waiting-cycle counter; stops once the budget is reached.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // The count holds the number of cycles already waited, so TIMEOUT-1 marks
  // the last allowed cycle and the request drops after exactly TIMEOUT cycles.
  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 16-bit pipelined CPU.
// Takes the EX/MEM bundle (ALUOut, Zero, StoreData, control bits) over an
// ExValid/ExReady handshake. Non-memory instructions retire one cycle later;
// loads/stores are issued on the DmemReq/DmemAck interface and EX is stalled
// until the acknowledge. Writeback outputs (WbValid, WbRegWrite, WbWriteReg,
// WbData, BranchTaken) are registered.
// Build option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// unacknowledged cycles, retiring it without a register write and setting
// the sticky MemFault flag. Without it MemFault is tied to 0.
// Ports:
//   Clk, Reset_n                  - clock, asynchronous active-low reset
//   ExValid/ExReady               - EX handshake
//   ALUOut, Zero, StoreData       - EX datapath results
//   MemRead, MemWrite, RegWrite,
//   WriteReg, Branch              - EX/MEM control
//   DmemReq/We/Addr/WData,
//   DmemAck/RData                 - data memory port
//   WbValid, WbRegWrite,
//   WbWriteReg, WbData            - writeback bundle
//   BranchTaken                   - branch resolved taken, aligned with WbValid
//   MemFault                      - sticky access timeout flag
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int REG_W   = CPU_REG_W
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = CPU_TIMEOUT
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ExValid,
  output logic              ExReady,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              Zero,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic              Branch,
  output logic              DmemReq,
  output logic              DmemWe,
  output logic [DATA_W-1:0] DmemAddr,
  output logic [DATA_W-1:0] DmemWData,
  input  logic              DmemAck,
  input  logic [DATA_W-1:0] DmemRData,
  output logic              WbValid,
  output logic              WbRegWrite,
  output logic [REG_W-1:0]  WbWriteReg,
  output logic [DATA_W-1:0] WbData,
  output logic              BranchTaken,
  output logic              MemFault
);

  mem_state_e        state_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              rw_q;
  logic [REG_W-1:0]  wreg_q;
  logic              wb_valid_q;
  logic              wb_rw_q;
  logic [REG_W-1:0]  wb_wreg_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              bt_q;

`ifdef MEM_TIMEOUT_EN
  logic tmo_expired_s;
  logic mem_fault_q;

  dmem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clear_i  (state_q == MS_IDLE),
    .enable_i ((state_q == MS_ACCESS) && !DmemAck),
    .expired_o(tmo_expired_s)
  );

  // Sticky fault flag, set when an access is abandoned without an acknowledge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_fault_q <= 1'b0;
    end else if ((state_q == MS_ACCESS) && !DmemAck && tmo_expired_s) begin
      mem_fault_q <= 1'b1;
    end else begin
      mem_fault_q <= mem_fault_q;
    end
  end

  assign MemFault = mem_fault_q;
`else
  assign MemFault = 1'b0;
`endif

  // Access FSM plus capture and writeback registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= MS_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rw_q       <= 1'b0;
      wreg_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_wreg_q  <= '0;
      wb_data_q  <= '0;
      bt_q       <= 1'b0;
    end else begin
      // Pulse outputs return to 0 unless a retirement below overrides them.
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      bt_q       <= 1'b0;
      case (state_q)
        MS_IDLE: begin
          if (ExValid && (MemRead || MemWrite)) begin
            state_q <= MS_ACCESS;
            addr_q  <= ALUOut;
            wdata_q <= StoreData;
            // A read takes precedence when both direction bits are set.
            we_q    <= MemWrite & ~MemRead;
            rw_q    <= RegWrite;
            wreg_q  <= WriteReg;
          end else if (ExValid) begin
            wb_valid_q <= 1'b1;
            wb_rw_q    <= RegWrite;
            wb_wreg_q  <= WriteReg;
            wb_data_q  <= ALUOut;
            bt_q       <= Branch & Zero;
          end else begin
            state_q <= MS_IDLE;
          end
        end
        MS_ACCESS: begin
          if (DmemAck) begin
            state_q    <= MS_IDLE;
            wb_valid_q <= 1'b1;
            wb_wreg_q  <= wreg_q;
            if (we_q) begin
              wb_data_q <= addr_q;
              wb_rw_q   <= 1'b0;
            end else begin
              wb_data_q <= DmemRData;
              wb_rw_q   <= rw_q;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_expired_s) begin
            // Abandoned access: retire it so EX is released, but write nothing.
            state_q    <= MS_IDLE;
            wb_valid_q <= 1'b1;
            wb_wreg_q  <= wreg_q;
            wb_data_q  <= addr_q;
          end
`endif
          else begin
            state_q <= MS_ACCESS;
          end
        end
        default: begin
          state_q <= MS_IDLE;
        end
      endcase
    end
  end

  assign ExReady     = (state_q == MS_IDLE);
  assign DmemReq     = (state_q == MS_ACCESS);
  assign DmemWe      = (state_q == MS_ACCESS) & we_q;
  assign DmemAddr    = addr_q;
  assign DmemWData   = wdata_q;
  assign WbValid     = wb_valid_q;
  assign WbRegWrite  = wb_rw_q;
  assign WbWriteReg  = wb_wreg_q;
  assign WbData      = wb_data_q;
  assign BranchTaken = bt_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Expected writeback records
// are queued when an instruction is handed over and compared (fields plus
// retirement cycle) whenever WbValid pulses. A responder models the data
// memory with a programmable acknowledge delay.
module tb_mem_stage;

  logic        Clk;
  logic        Reset_n;
  logic        ExValid;
  logic        ExReady;
  logic [15:0] ALUOut;
  logic        Zero;
  logic [15:0] StoreData;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic        Branch;
  logic        DmemReq;
  logic        DmemWe;
  logic [15:0] DmemAddr;
  logic [15:0] DmemWData;
  logic        DmemAck;
  logic [15:0] DmemRData;
  logic        WbValid;
  logic        WbRegWrite;
  logic [2:0]  WbWriteReg;
  logic [15:0] WbData;
  logic        BranchTaken;
  logic        MemFault;

  mem_stage dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ExValid    (ExValid),
    .ExReady    (ExReady),
    .ALUOut     (ALUOut),
    .Zero       (Zero),
    .StoreData  (StoreData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .Branch     (Branch),
    .DmemReq    (DmemReq),
    .DmemWe     (DmemWe),
    .DmemAddr   (DmemAddr),
    .DmemWData  (DmemWData),
    .DmemAck    (DmemAck),
    .DmemRData  (DmemRData),
    .WbValid    (WbValid),
    .WbRegWrite (WbRegWrite),
    .WbWriteReg (WbWriteReg),
    .WbData     (WbData),
    .BranchTaken(BranchTaken),
    .MemFault   (MemFault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] data;
    logic        rw;
    logic [2:0]  wr;
    logic        bt;
    logic        chk_data;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [15:0] alu;
    logic        z;
    logic        rw;
    logic [2:0]  wr;
    logic        br;
    logic [15:0] e_data;
    logic        e_rw;
    logic        e_bt;
  } vec_t;

  wb_t         sb[$];
  vec_t        vec[6];
  int          total;
  int          bad;
  int          cyc;
  int          ack_delay;
  int          req_cycles;
  logic [15:0] rd_data;
  logic        inject_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compares each WbValid pulse against the oldest queued expectation.
  task automatic monitor_loop();
    wb_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (WbValid) begin
        chk("wb_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.chk_data) chk("wb_data", 32'(WbData), 32'(e.data));
          chk("wb_regwrite", 32'(WbRegWrite), 32'(e.rw));
          chk("wb_writereg", 32'(WbWriteReg), 32'(e.wr));
          chk("wb_branch", 32'(BranchTaken), 32'(e.bt));
          chk("wb_latency", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_branch", 32'(BranchTaken), 32'd0);
        chk("idle_regwrite", 32'(WbRegWrite), 32'd0);
      end
    end
  endtask

  // Data memory: acknowledges in ACCESS cycle ack_delay (0 = never).
  task automatic responder_loop();
    int n = 0;
    forever begin
      @(negedge Clk);
      if (DmemReq) begin
        n++;
        req_cycles++;
      end else begin
        n = 0;
      end
      DmemAck   = (DmemReq && (ack_delay != 0) && (n == ack_delay)) || inject_ack;
      DmemRData = rd_data;
    end
  endtask

  // Presents one instruction, waits (bounded) for acceptance, queues its result.
  task automatic send(input logic [15:0] alu, input logic z, input logic [15:0] sd,
                      input logic mr, input logic mw, input logic rw, input logic [2:0] wr,
                      input logic br, input logic [15:0] e_data, input logic e_rw,
                      input logic e_bt, input logic e_chk, input int lat, input logic push);
    int  g = 0;
    wb_t r;
    ExValid = 1'b1; ALUOut = alu; Zero = z; StoreData = sd;
    MemRead = mr; MemWrite = mw; RegWrite = rw; WriteReg = wr; Branch = br;
    while (!ExReady && g < 100) begin
      @(negedge Clk);
      g++;
    end
    chk("accept_bound", 32'(ExReady), 32'd1);
    if (push) begin
      r.data = e_data; r.rw = e_rw; r.wr = wr; r.bt = e_bt;
      r.chk_data = e_chk; r.cyc = cyc + lat;
      sb.push_back(r);
    end
    @(negedge Clk);
    ExValid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge Clk);
      g++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int r0;
    Reset_n = 1'b0; ExValid = 1'b0; ALUOut = 16'h0; Zero = 1'b0; StoreData = 16'h0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; WriteReg = 3'd0; Branch = 1'b0;
    DmemAck = 1'b0; DmemRData = 16'h0; inject_ack = 1'b0; ack_delay = 0; rd_data = 16'h0;
    total = 0; bad = 0; cyc = 0; req_cycles = 0;

    vec[0] = '{16'd33,   1'b0, 1'b1, 3'd1, 1'b0, 16'd33,   1'b1, 1'b0};
    vec[1] = '{16'hFFF8, 1'b0, 1'b1, 3'd2, 1'b0, 16'hFFF8, 1'b1, 1'b0};
    vec[2] = '{16'd6,    1'b0, 1'b1, 3'd3, 1'b0, 16'd6,    1'b1, 1'b0};
    vec[3] = '{16'd0,    1'b1, 1'b0, 3'd0, 1'b1, 16'd0,    1'b0, 1'b1};
    vec[4] = '{16'd27,   1'b0, 1'b0, 3'd0, 1'b1, 16'd27,   1'b0, 1'b0};
    vec[5] = '{16'd0,    1'b1, 1'b1, 3'd4, 1'b0, 16'd0,    1'b1, 1'b0};

    fork
      monitor_loop();
      responder_loop();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state.
    repeat (3) @(negedge Clk);
    chk("rst_exready", 32'(ExReady), 32'd1);
    chk("rst_dmemreq", 32'(DmemReq), 32'd0);
    chk("rst_dmemwe", 32'(DmemWe), 32'd0);
    chk("rst_dmemaddr", 32'(DmemAddr), 32'd0);
    chk("rst_wbvalid", 32'(WbValid), 32'd0);
    chk("rst_wbdata", 32'(WbData), 32'd0);
    chk("rst_wbwritereg", 32'(WbWriteReg), 32'd0);
    chk("rst_memfault", 32'(MemFault), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Non-memory burst, back to back.
    r0 = req_cycles;
    for (int i = 0; i < 6; i++) begin
      chk("burst_exready", 32'(ExReady), 32'd1);
      send(vec[i].alu, vec[i].z, 16'h0, 1'b0, 1'b0, vec[i].rw, vec[i].wr, vec[i].br,
           vec[i].e_data, vec[i].e_rw, vec[i].e_bt, 1'b1, 1, 1'b1);
    end
    wait_drain();
    chk("burst_no_req", 32'(req_cycles), 32'(r0));

    // Load acknowledged in the third ACCESS cycle.
    ack_delay = 3; rd_data = 16'hBEEF;
    send(16'h0010, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("load_req", 32'(DmemReq), 32'd1);
      chk("load_addr", 32'(DmemAddr), 32'h0010);
      chk("load_we", 32'(DmemWe), 32'd0);
      chk("load_exready", 32'(ExReady), 32'd0);
      @(negedge Clk);
    end
    chk("load_done_req", 32'(DmemReq), 32'd0);
    chk("load_done_exready", 32'(ExReady), 32'd1);
    send(16'h0077, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 16'h0077, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    wait_drain();

    // Store acknowledged in the first ACCESS cycle (latency 2).
    ack_delay = 1;
    send(16'h0020, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    chk("store_req", 32'(DmemReq), 32'd1);
    chk("store_we", 32'(DmemWe), 32'd1);
    chk("store_addr", 32'(DmemAddr), 32'h0020);
    chk("store_wdata", 32'(DmemWData), 32'h1234);
    @(negedge Clk);
    chk("store_exready", 32'(ExReady), 32'd1);
    wait_drain();

    // Read and write both set: load wins, no branch for memory ops.
    ack_delay = 2; rd_data = 16'h5A5A;
    send(16'h0030, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1, 3, 1'b1);
    chk("rw_both_we", 32'(DmemWe), 32'd0);
    wait_drain();

    // Store then load with ExValid held through the stall.
    ack_delay = 2; rd_data = 16'h1111;
    send(16'h0050, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    send(16'h0052, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b1, 3, 1'b1);
    wait_drain();

    // Reset during an access, then a stray acknowledge.
    ack_delay = 0;
    send(16'h0060, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("mid_req", 32'(DmemReq), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(DmemReq), 32'd0);
    chk("mid_rst_exready", 32'(ExReady), 32'd1);
    chk("mid_rst_wbdata", 32'(WbData), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1 inject_ack = 1'b1;
    @(posedge Clk);
    #1 inject_ack = 1'b0;
    repeat (2) @(negedge Clk);
    chk("late_ack_req", 32'(DmemReq), 32'd0);
    chk("late_ack_exready", 32'(ExReady), 32'd1);
    chk("late_ack_wbvalid", 32'(WbValid), 32'd0);
    wait_drain();

`ifdef MEM_TIMEOUT_EN
    // Acknowledge in the last allowed cycle wins over the timeout.
    ack_delay = 15; rd_data = 16'h7777;
    send(16'h0070, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 16'h7777, 1'b1, 1'b0, 1'b1, 16, 1'b1);
    wait_drain();
    chk("ack_wins_fault", 32'(MemFault), 32'd0);

    // No acknowledge: abandoned after 15 ACCESS cycles.
    ack_delay = 0;
    send(16'h0072, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16, 1'b1);
    for (int i = 0; i < 15; i++) begin
      chk("tmo_req", 32'(DmemReq), 32'd1);
      @(negedge Clk);
    end
    chk("tmo_req_drop", 32'(DmemReq), 32'd0);
    chk("tmo_fault", 32'(MemFault), 32'd1);
    repeat (3) @(negedge Clk);
    chk("tmo_fault_sticky", 32'(MemFault), 32'd1);
    wait_drain();
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("tmo_fault_cleared", 32'(MemFault), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
`else
    chk("fault_tied_low", 32'(MemFault), 32'd0);
`endif

    wait_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
